// File: rtl/regfile_seq.sv
// Single-issue sequencer driving a 32x16 registered-read register file: read, execute, serial shift, write back.
// Optional REGFILE_SEQ_ASR_EN makes SHR arithmetic (sign fill) instead of logical (zero fill).
module regfile_seq #(
    parameter int DW = 16,
    parameter int AW = 5,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [DW-1:0] cmd_imm,
    input  logic [SW-1:0] cmd_sh,
    output logic          resp_valid,
    output logic [DW-1:0] resp_data,
    output logic          resp_carry,
    output logic          rf_write,
    output logic [AW-1:0] rf_wrAddr,
    output logic [DW-1:0] rf_wrData,
    output logic          rf_readA,
    output logic [AW-1:0] rf_rdAddrA,
    output logic          rf_readB,
    output logic [AW-1:0] rf_rdAddrB,
    input  logic [DW-1:0] rf_rdDataA,
    input  logic [DW-1:0] rf_rdDataB,
    output logic          rf_wshift,
    output logic [DW-1:0] rf_shData
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_SH, S_WB} state_t;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_RD  = 3'b111;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
    logic [SW-1:0] sh_q, sh_d, cnt_q, cnt_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [DW:0]   sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sum     = {1'b0, rf_rdDataA} + {1'b0, rf_rdDataB};
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    ra_d    = cmd_ra;
                    rb_d    = cmd_rb;
                    sh_d    = cmd_sh;
                    carry_d = 1'b0;
                    if (cmd_op == OP_LDI) begin
                        acc_d   = cmd_imm;
                        state_d = S_WB;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: state_d = S_EX;
            S_EX: begin
                carry_d = 1'b0;
                state_d = S_WB;
                case (op_q)
                    OP_ADD: {carry_d, acc_d} = sum;
                    OP_SUB: begin
                        acc_d   = rf_rdDataA - rf_rdDataB;
                        carry_d = (rf_rdDataA < rf_rdDataB);
                    end
                    OP_AND: acc_d = rf_rdDataA & rf_rdDataB;
                    OP_SHL, OP_SHR: begin
                        acc_d = rf_rdDataA;
                        cnt_d = sh_q;
                        if (sh_q != '0) state_d = S_SH;
                    end
                    default: acc_d = rf_rdDataA;
                endcase
            end
            S_SH: begin
                if (op_q == OP_SHL) begin
                    acc_d = {acc_q[DW-2:0], 1'b0};
                end else begin
`ifdef REGFILE_SEQ_ASR_EN
                    acc_d = {acc_q[DW-1], acc_q[DW-1:1]};
`else
                    acc_d = {1'b0, acc_q[DW-1:1]};
`endif
                end
                cnt_d = cnt_q - 1'b1;
                // Leave on the step that consumes the last count, so exactly sh cycles are spent here.
                if (cnt_q == 1) state_d = S_WB;
            end
            S_WB: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode the registered state only, so every drive is zero outside its own state.
    always_comb begin
        cmd_ready  = (state_q == S_IDLE);
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_carry = 1'b0;
        rf_write   = 1'b0;
        rf_wrAddr  = '0;
        rf_wrData  = '0;
        rf_readA   = 1'b0;
        rf_rdAddrA = '0;
        rf_readB   = 1'b0;
        rf_rdAddrB = '0;
        rf_wshift  = 1'b0;
        rf_shData  = '0;
        if (state_q == S_RD) begin
            rf_readA   = 1'b1;
            rf_rdAddrA = ra_q;
            rf_readB   = 1'b1;
            rf_rdAddrB = rb_q;
        end
        if (state_q == S_WB) begin
            resp_valid = 1'b1;
            resp_data  = acc_q;
            resp_carry = carry_q;
            case (op_q)
                OP_RD: ;
                OP_SHL, OP_SHR: begin
                    rf_wshift = 1'b1;
                    rf_wrAddr = rd_q;
                    rf_shData = acc_q;
                end
                default: begin
                    rf_write  = 1'b1;
                    rf_wrAddr = rd_q;
                    rf_wrData = acc_q;
                end
            endcase
        end
    end
endmodule

// File: doc/regfile_seq.md
Name: regfile_seq

Overview:
- Single-issue command sequencer in front of the 32x16 register file with registered read ports.
- Accepts one register-to-register command at a time over a valid/ready handshake and drives the regfile read, write and shift-write ports in order.
- Returns the result on a one-cycle response strobe.
- Performs shifts serially, one bit per cycle, and writes the result back through the regfile shift-write port.

Parameters:
DW, 16, data width (must match regfile word width)
AW, 5, register address width (32 registers)
SW, 4, shift amount width (0..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_op  input  3  000 MOV, 001 ADD, 010 SUB, 011 AND, 100 SHL, 101 SHR, 110 LDI, 111 RD
cmd_rd  input  AW  destination register
cmd_ra  input  AW  source A
cmd_rb  input  AW  source B
cmd_imm  input  DW  immediate for LDI
cmd_sh  input  SW  shift amount for SHL/SHR
resp_valid  output  1  one-cycle result strobe
resp_data  output  DW  result value
resp_carry  output  1  ADD carry-out / SUB borrow; 0 for all other ops
rf_write, rf_wrAddr[AW], rf_wrData[DW]  output  write port drive
rf_readA, rf_rdAddrA[AW], rf_readB, rf_rdAddrB[AW]  output  read port drive
rf_rdDataA, rf_rdDataB  input  DW  regfile registered read data
rf_wshift, rf_shData[DW]  output  shift-write port drive (rf_wshift reuses rf_wrAddr)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0 except cmd_ready=1.
  - An in-flight command is dropped with no regfile write and no resp_valid.
- Handshake: a command is accepted on a rising edge with cmd_valid & cmd_ready. All cmd_* fields are latched on that edge. cmd_* are ignored outside IDLE.
- FSM states: IDLE, RD, EX, SH, WB.
- IDLE:
  - Accept LDI -> WB, with acc=imm.
  - Accept any other op -> RD.
- RD (1 cycle): rf_readA=1, rf_rdAddrA=ra, rf_readB=1, rf_rdAddrB=rb -> EX.
- EX: operands are taken from rf_rdDataA/B (valid this cycle due to registered reads).
  - MOV/RD: acc=A.
  - ADD: {carry,acc}=A+B, mod 2^16.
  - SUB: acc=A-B, carry=(A<B).
  - AND: acc=A&B.
  - SHL/SHR: acc=A, cnt=cmd_sh. If cnt==0 -> WB, else -> SH.
  - All non-shift ops -> WB.
- SH:
  - Each cycle, acc shifts one bit (SHL: zero into LSB; SHR: see Optional Feature) and cnt decrements.
  - Leave to WB in the cycle cnt goes 1->0, i.e. exactly cmd_sh cycles are spent in SH.
- WB (1 cycle):
  - resp_valid=1, resp_data=acc, resp_carry as computed.
  - MOV/ADD/SUB/AND/LDI: rf_write=1, rf_wrAddr=rd, rf_wrData=acc.
  - SHL/SHR: rf_wshift=1, rf_wrAddr=rd, rf_shData=acc; rf_write=0.
  - RD: no write.
  - -> IDLE.
- Latency from accept edge (cycle 0) to resp_valid:
  - LDI: cycle 1.
  - ALU/MOV/RD: cycle 3.
  - Shift by n: cycle 3+n.
- Hazards:
  - rd==ra or rd==rb is legal; operands are read before the write.
  - A back-to-back command reads at the earliest 2 cycles after the previous WB, so it always sees the new value.
- rf_write and rf_wshift are never asserted in the same cycle.
- All regfile drive outputs are 0 when not in their state.
- Throughput: one command per (latency+1) cycles.

Optional Feature:
- Macro REGFILE_SEQ_ASR_EN.
- Defined: SHR is arithmetic; bit 15 is replicated into the MSB on every step.
- Undefined: SHR is logical; zero fill.
- All other behaviour is identical.

Test Plan:
- LDI r3=0x1234 -> resp_valid on cycle 1, resp_data=0x1234, rf_write=1, rf_wrAddr=3; a following RD r3 returns 0x1234 on its cycle 3.
- r1=0xFFFF, r2=0x0002, ADD r4=r1+r2 -> resp_data=0x0001, resp_carry=1; SUB r5=r2-r1 -> 0x0003, resp_carry=1.
- r6=0x8001, SHL r7=r6 by 4 -> resp_valid at cycle 7, rf_wshift=1, rf_shData=0x0010, rf_write=0; same with shift 0 -> cycle 3, data 0x8001.
- r6=0x8001, SHR by 1 -> 0x4000 without macro, 0xC000 with REGFILE_SEQ_ASR_EN.
- Drop rst_n low during SH of a shift by 10 -> state IDLE immediately, cmd_ready=1, no rf_wshift pulse, target register unchanged on later RD.
- cmd_valid held high with 3 queued commands -> cmd_ready low from accept until WB completes; each command accepted only in IDLE, none lost or duplicated.
